ft_channel_pipe: RTL and testbench
==================================

# ft_channel_pipe

Parametrised, pipelined feedthrough channel block. It carries CHANNELS independent WIDTH-bit buses across a hierarchical tile through DEPTH elastic register stages each. Every channel has a valid/ready handshake, a synchronous flush and an occupancy count. It is inserted wherever a net must cross an intermediate module and needs retiming rather than a bare wire.

## Interface
- WIDTH, 2, data bits per channel (>=1)
- CHANNELS, 2, number of independent channels (>=1)
- DEPTH, 2, register stages per channel (>=0; 0 = combinational feedthrough)
- CW, derived = $clog2(DEPTH+1) (min 1), occupancy counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  CHANNELS  per-channel upstream valid
- in_ready  out  CHANNELS  per-channel upstream ready
- in_data  in  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  per-channel downstream valid
- out_ready  in  CHANNELS  per-channel downstream ready
- out_data  out  CHANNELS*WIDTH  same packing as in_data
- flush  in  CHANNELS  per-channel synchronous clear
- occ  out  CHANNELS*CW  per-channel count of valid stages, channel c at [c*CW +: CW]

## Operation
- Channels are fully independent; there is no cross-channel coupling in data, handshake, flush or occupancy.
- A transfer occurs on a port when valid && ready at a rising clk edge.
- Each channel is a chain of DEPTH stages, s[0] (input side) to s[DEPTH-1] (output side). Each stage holds vld and data.
- Stage k accepts when rdy[k] = !vld[k] || rdy[k+1]; rdy[DEPTH] = out_ready.
- in_ready = rdy[0] && !flush; out_valid = vld[DEPTH-1]; out_data = data of s[DEPTH-1].
- Stage k loads the upstream word when rdy[k] is high. vld[k] takes the upstream valid: in_valid for k=0, vld[k-1] otherwise.
- A stage's data register updates only when the stage loads a valid word. Data holds while the stage is stalled.
- flush[c] high at an edge clears all vld of channel c and occ[c]. Data registers are don't-care after flush.
  - in_ready[c] is low during flush, so no input is accepted; flush wins over a simultaneous input.
  - out_valid[c] may still be high in the flush cycle if it was before. A downstream transfer in that cycle counts as delivered. Nothing is delivered after flush.
- occ = number of set vld bits in the channel, 0..DEPTH. It updates each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither. It never wraps; reaching DEPTH implies in_ready low unless out_ready is high.
- DEPTH = 0 mode: out_valid = in_valid, out_data = in_data, in_ready = out_ready. flush has no effect, occ is constant 0, and there is no state.
- Ordering is strict FIFO per channel: no drop, no duplicate, no reorder.

## Timing
- Reset (rst_n low, asynchronous): all vld = 0, all data registers = 0, occ = 0, out_valid = 0, out_data = 0, in_ready = 1 wherever flush is low.
- Reset deassertion may be asynchronous to clk. The first transfer is the first edge after rst_n high.
- Reset mid-operation discards all in-flight words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge t appears on out_valid/out_data after edge t+DEPTH-1 if not stalled, i.e. available for transfer at edge t+DEPTH.
- Throughput: one word per cycle per channel with out_ready held high.
- Backpressure: rdy is combinational from out_ready through all stages to in_ready. The path depth is DEPTH, an accepted timing cost.
- When full (occ = DEPTH) and out_ready is high, a simultaneous input and output transfer occurs and occ stays DEPTH.
- All outputs except in_ready are registered when DEPTH >= 1.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with occ=2 -> out_valid=0, occ=0, out_data=0 immediately; after release, in_ready=1 on all channels.
- Streaming, WIDTH=2, DEPTH=2, out_ready=1: send 0,1,2,3 back-to-back on ch0 -> out_valid first high after 2nd edge, outputs 0,1,2,3 on consecutive cycles, occ steady at 2.
- Backpressure: fill ch1 with out_ready=0 -> occ=2, in_ready=0 after 2 accepts. Then raise out_ready with in_valid held -> transfer in and out in the same cycle, occ stays 2, no word lost.
- Flush collision: flush[0]=1 with in_valid[0]=1 and occ[0]=1 -> in_ready[0]=0, next cycle occ[0]=0 and out_valid[0]=0. Ch1 is unaffected and keeps streaming.
- Channel independence, CHANNELS=4, WIDTH=8: distinct random streams with random out_ready per channel -> scoreboard shows per-channel order preserved, and occ always equals accepted minus delivered.
- DEPTH=0 build: toggle in_valid/out_ready -> out_valid follows in_valid and in_ready follows out_ready in the same cycle, data passes unchanged, occ=0.

Source files
------------

// File: rtl/ft_channel_pipe.sv
// CHANNELS independent elastic register pipelines of DEPTH stages each, with
// per-channel valid/ready handshake, synchronous flush and occupancy count.
module ft_channel_pipe #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 2,
    localparam int unsigned CW      = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       flush,
    output logic [CHANNELS*CW-1:0]    occ
);

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        if (DEPTH == 0) begin : g_wire
            // Zero-depth build: plain wires, no state, flush ignored.
            assign out_valid[c]               = in_valid[c];
            assign out_data[c*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
            assign in_ready[c]                = out_ready[c];
            assign occ[c*CW +: CW]            = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0]            vld_q, vld_d;
            logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
            logic [DEPTH-1:0]            rdy;
            logic                        rdy_acc;
            logic [CW-1:0]               occ_q, occ_d;
            logic                        in_xfer;
            logic                        out_xfer;

            // Stage k is ready if it or any stage downstream of it has a bubble.
            always_comb begin
                rdy_acc = out_ready[c];
                rdy     = '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    rdy_acc = rdy_acc | ~vld_q[int'(DEPTH) - 1 - i];
                    rdy[int'(DEPTH) - 1 - i] = rdy_acc;
                end
            end

            assign in_ready[c] = rdy[0] & ~flush[c];
            assign in_xfer     = in_valid[c] & in_ready[c];
            assign out_xfer    = vld_q[DEPTH-1] & out_ready[c];

            // Stage advance; data only captured when a valid word moves in.
            always_comb begin
                vld_d  = vld_q;
                data_d = data_q;
                if (rdy[0]) begin
                    vld_d[0] = in_valid[c];
                    if (in_valid[c]) begin
                        data_d[0] = in_data[c*WIDTH +: WIDTH];
                    end
                end
                for (int k = 1; k < int'(DEPTH); k++) begin
                    if (rdy[k]) begin
                        vld_d[k] = vld_q[k-1];
                        if (vld_q[k-1]) begin
                            data_d[k] = data_q[k-1];
                        end
                    end
                end
                if (flush[c]) begin
                    vld_d = '0;
                end
            end

            always_comb begin
                occ_d = occ_q;
                if (flush[c]) begin
                    occ_d = '0;
                end else if (in_xfer && !out_xfer) begin
                    occ_d = occ_q + CW'(1);
                end else if (!in_xfer && out_xfer) begin
                    occ_d = occ_q - CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= '0;
                    data_q <= '0;
                    occ_q  <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                    occ_q  <= occ_d;
                end
            end

            assign out_valid[c]               = vld_q[DEPTH-1];
            assign out_data[c*WIDTH +: WIDTH] = data_q[DEPTH-1];
            assign occ[c*CW +: CW]            = occ_q;
        end
    end

endmodule

// File: tb/tb_ft_channel_pipe.sv
// Bench for ft_channel_pipe: directed scenarios on a 2x2x2 build, a randomized
// scoreboard run on a 4-channel 8-bit build, and a zero-depth feedthrough build.
module tb_ft_channel_pipe;

    localparam int unsigned M_W = 2, M_C = 2, M_D = 2, M_CW = 2;
    localparam int unsigned W_W = 8, W_C = 4, W_D = 3, W_CW = 2;
    localparam int unsigned Z_W = 8, Z_C = 2, Z_D = 0, Z_CW = 1;
    localparam int RAND_CYC = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [M_C-1:0]      m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_flush;
    logic [M_C*M_W-1:0]  m_in_data, m_out_data;
    logic [M_C*M_CW-1:0] m_occ;

    logic [W_C-1:0]      w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_flush;
    logic [W_C*W_W-1:0]  w_in_data, w_out_data;
    logic [W_C*W_CW-1:0] w_occ;

    logic [Z_C-1:0]      z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_flush;
    logic [Z_C*Z_W-1:0]  z_in_data, z_out_data;
    logic [Z_C*Z_CW-1:0] z_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ft_channel_pipe #(.WIDTH(M_W), .CHANNELS(M_C), .DEPTH(M_D)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .flush(m_flush), .occ(m_occ)
    );

    ft_channel_pipe #(.WIDTH(W_W), .CHANNELS(W_C), .DEPTH(W_D)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .flush(w_flush), .occ(w_occ)
    );

    ft_channel_pipe #(.WIDTH(Z_W), .CHANNELS(Z_C), .DEPTH(Z_D)) u_zero (
        .clk(clk), .rst_n(rst_n),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .flush(z_flush), .occ(z_occ)
    );

    task automatic idle_inputs();
        m_in_valid = '0; m_out_ready = '0; m_flush = '0; m_in_data = '0;
        w_in_valid = '0; w_out_ready = '0; w_flush = '0; w_in_data = '0;
        z_in_valid = '0; z_out_ready = '0; z_flush = '0; z_in_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        m_out_ready   = '0;
        m_in_valid    = 2'b01;
        m_in_data     = {2'd0, 2'd3};
        @(negedge clk);
        m_in_data     = {2'd0, 2'd2};
        @(negedge clk);
        m_in_valid    = '0;
        #1;
        total++; if (m_occ[1:0] !== 2'd2) begin bad++; $display("FAIL rst_pre_occ: got %0d want 2", m_occ[1:0]); end
        total++; if (m_out_data[1:0] !== 2'd3) begin bad++; $display("FAIL rst_pre_data: got %0d want 3", m_out_data[1:0]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_out_valid !== 2'b00) begin bad++; $display("FAIL rst_ov: got %b want 00", m_out_valid); end
        total++; if (m_occ !== '0) begin bad++; $display("FAIL rst_occ: got %h want 0", m_occ); end
        total++; if (m_out_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", m_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (m_in_ready !== 2'b11) begin bad++; $display("FAIL rst_in_ready: got %b want 11", m_in_ready); end
        total++; if (w_in_ready !== 4'b1111) begin bad++; $display("FAIL rst_w_in_ready: got %b want 1111", w_in_ready); end
    endtask

    task automatic test_stream();
        int acc, del, e_occ;
        logic e_ov;
        do_reset();
        m_out_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_in_valid[0]  = (i < 4);
            m_in_data[1:0] = 2'(i);
            #1;
            e_ov  = (i >= 2 && i < 6);
            acc   = (i < 4) ? i : 4;
            del   = (i <= 2) ? 0 : ((i - 2 > 4) ? 4 : i - 2);
            e_occ = acc - del;
            total++; if (m_out_valid[0] !== e_ov) begin bad++; $display("FAIL stream_ov cyc%0d: got %b want %b", i, m_out_valid[0], e_ov); end
            if (e_ov) begin
                total++; if (m_out_data[1:0] !== 2'(i - 2)) begin bad++; $display("FAIL stream_data cyc%0d: got %0d want %0d", i, m_out_data[1:0], i - 2); end
            end
            total++; if (m_occ[1:0] !== 2'(e_occ)) begin bad++; $display("FAIL stream_occ cyc%0d: got %0d want %0d", i, m_occ[1:0], e_occ); end
            total++; if (m_in_ready[0] !== 1'b1) begin bad++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", i, m_in_ready[0]); end
        end
        m_in_valid = '0;
    endtask

    task automatic test_backpressure();
        int iv[7]  = '{1, 1, 1, 1, 0, 0, 0};
        int ordy[7] = '{0, 0, 0, 1, 1, 1, 1};
        int dat[7] = '{1, 2, 3, 3, 0, 0, 0};
        int eir[7] = '{1, 1, 0, 1, 1, 1, 1};
        int eoc[7] = '{0, 1, 2, 2, 2, 1, 0};
        int eov[7] = '{0, 0, 1, 1, 1, 1, 0};
        int eod[7] = '{0, 0, 1, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m_in_valid[1]  = 1'(iv[i]);
            m_out_ready[1] = 1'(ordy[i]);
            m_in_data[3:2] = 2'(dat[i]);
            #1;
            total++; if (m_in_ready[1] !== 1'(eir[i])) begin bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %0d", i, m_in_ready[1], eir[i]); end
            total++; if (m_occ[3:2] !== 2'(eoc[i])) begin bad++; $display("FAIL bp_occ cyc%0d: got %0d want %0d", i, m_occ[3:2], eoc[i]); end
            total++; if (m_out_valid[1] !== 1'(eov[i])) begin bad++; $display("FAIL bp_ov cyc%0d: got %b want %0d", i, m_out_valid[1], eov[i]); end
            if (eov[i] != 0) begin
                total++; if (m_out_data[3:2] !== 2'(eod[i])) begin bad++; $display("FAIL bp_data cyc%0d: got %0d want %0d", i, m_out_data[3:2], eod[i]); end
            end
        end
        m_in_valid = '0;
    endtask

    task automatic test_flush();
        int iv0[6] = '{1, 1, 0, 0, 0, 0};
        int fl0[6] = '{0, 1, 0, 0, 0, 0};
        int or0[6] = '{0, 0, 1, 1, 1, 1};
        int eir[6] = '{1, 0, 1, 1, 1, 1};
        int eoc[6] = '{0, 1, 0, 0, 0, 0};
        int acc, del;
        logic e_ov;
        do_reset();
        m_out_ready[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m_in_valid[0]  = 1'(iv0[i]);
            m_flush[0]     = 1'(fl0[i]);
            m_out_ready[0] = 1'(or0[i]);
            m_in_data[1:0] = 2'(i + 2);
            m_in_valid[1]  = (i < 4);
            m_in_data[3:2] = 2'(i);
            #1;
            total++; if (m_in_ready[0] !== 1'(eir[i])) begin bad++; $display("FAIL fl_in_ready cyc%0d: got %b want %0d", i, m_in_ready[0], eir[i]); end
            total++; if (m_occ[1:0] !== 2'(eoc[i])) begin bad++; $display("FAIL fl_occ cyc%0d: got %0d want %0d", i, m_occ[1:0], eoc[i]); end
            total++; if (m_out_valid[0] !== 1'b0) begin bad++; $display("FAIL fl_ov cyc%0d: got %b want 0", i, m_out_valid[0]); end
            e_ov = (i >= 2);
            acc  = (i < 4) ? i : 4;
            del  = (i <= 2) ? 0 : i - 2;
            total++; if (m_out_valid[1] !== e_ov) begin bad++; $display("FAIL fl_ch1_ov cyc%0d: got %b want %b", i, m_out_valid[1], e_ov); end
            if (e_ov) begin
                total++; if (m_out_data[3:2] !== 2'(i - 2)) begin bad++; $display("FAIL fl_ch1_data cyc%0d: got %0d want %0d", i, m_out_data[3:2], i - 2); end
            end
            total++; if (m_occ[3:2] !== 2'(acc - del)) begin bad++; $display("FAIL fl_ch1_occ cyc%0d: got %0d want %0d", i, m_occ[3:2], acc - del); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] sent [W_C][4096];
        int wr [W_C];
        int rd [W_C];
        int cnt;
        logic e_rdy;
        logic [7:0] d;
        do_reset();
        for (int c = 0; c < int'(W_C); c++) begin wr[c] = 0; rd[c] = 0; end
        for (int cyc = 0; cyc < RAND_CYC + int'(W_D) + 2; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < int'(W_C); c++) begin
                if (cyc < RAND_CYC) begin
                    w_in_valid[c]  = ($urandom_range(0, 3) != 0);
                    w_out_ready[c] = ($urandom_range(0, 2) != 0);
                    w_flush[c]     = ($urandom_range(0, 39) == 0);
                end else begin
                    w_in_valid[c]  = 1'b0;
                    w_out_ready[c] = 1'b1;
                    w_flush[c]     = 1'b0;
                end
                w_in_data[c*8 +: 8] = 8'($urandom);
            end
            #1;
            for (int c = 0; c < int'(W_C); c++) begin
                cnt   = wr[c] - rd[c];
                e_rdy = !w_flush[c] && (cnt < int'(W_D) || w_out_ready[c]);
                total++; if (w_in_ready[c] !== e_rdy) begin bad++; $display("FAIL rnd_in_ready c%0d cyc%0d: got %b want %b", c, cyc, w_in_ready[c], e_rdy); end
                total++; if (w_occ[c*2 +: 2] !== W_CW'(cnt)) begin bad++; $display("FAIL rnd_occ c%0d cyc%0d: got %0d want %0d", c, cyc, w_occ[c*2 +: 2], cnt); end
                if (w_out_valid[c] === 1'b1) begin
                    total++;
                    if (cnt == 0) begin
                        bad++; $display("FAIL rnd_spurious c%0d cyc%0d: got valid want nothing pending", c, cyc);
                    end else if (w_out_data[c*8 +: 8] !== sent[c][rd[c]]) begin
                        bad++; $display("FAIL rnd_order c%0d cyc%0d: got %h want %h", c, cyc, w_out_data[c*8 +: 8], sent[c][rd[c]]);
                    end
                    if (w_out_ready[c] && cnt != 0) rd[c]++;
                end
                if (w_flush[c]) begin
                    rd[c] = wr[c];
                end else if (w_in_valid[c] && e_rdy) begin
                    d = w_in_data[c*8 +: 8];
                    sent[c][wr[c]] = d;
                    wr[c]++;
                end
            end
        end
        #1;
        for (int c = 0; c < int'(W_C); c++) begin
            total++; if (wr[c] != rd[c]) begin bad++; $display("FAIL rnd_drain c%0d: got %0d pending want 0", c, wr[c] - rd[c]); end
            total++; if (w_out_valid[c] !== 1'b0) begin bad++; $display("FAIL rnd_drain_ov c%0d: got %b want 0", c, w_out_valid[c]); end
        end
        idle_inputs();
    endtask

    task automatic test_depth0();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            z_in_valid  = 2'($urandom);
            z_out_ready = 2'($urandom);
            z_flush     = 2'($urandom);
            z_in_data   = 16'($urandom);
            #1;
            total++; if (z_out_valid !== z_in_valid) begin bad++; $display("FAIL z_ov cyc%0d: got %b want %b", i, z_out_valid, z_in_valid); end
            total++; if (z_in_ready !== z_out_ready) begin bad++; $display("FAIL z_in_ready cyc%0d: got %b want %b", i, z_in_ready, z_out_ready); end
            total++; if (z_out_data !== z_in_data) begin bad++; $display("FAIL z_data cyc%0d: got %h want %h", i, z_out_data, z_in_data); end
            total++; if (z_occ !== 2'b00) begin bad++; $display("FAIL z_occ cyc%0d: got %b want 00", i, z_occ); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_depth0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
